// File: rtl/mem_resp.sv
// mem_resp: load-response stage; waits for RAM data, extracts/extends it and pulses ld_valid.
// Optional MEM_RESP_ALE_EN flags misaligned loads on ld_ale.
`timescale 1ns/1ps
`ifndef WD_RAM
`define WD_RAM 2'd1
`endif
`ifndef RAM_EXT_B
`define RAM_EXT_B 3'd0
`endif
`ifndef RAM_EXT_BU
`define RAM_EXT_BU 3'd1
`endif
`ifndef RAM_EXT_H
`define RAM_EXT_H 3'd2
`endif
`ifndef RAM_EXT_HU
`define RAM_EXT_HU 3'd3
`endif
module mem_resp #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_valid,
  input  logic [1:0]  mem_wd_sel,
  input  logic [31:0] mem_ram_addr,
  input  logic [2:0]  mem_ram_ext_op,
  input  logic [3:0]  mem_ram_we,
  input  logic [31:0] da_rdata,
  input  logic        da_rvalid,
  output logic        mem_stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        ld_err,
  output logic        ld_ale
);
  localparam int CW = $clog2(TIMEOUT + 1);
`ifdef MEM_RESP_ALE_EN
  localparam logic ALE = 1'b1;
`else
  localparam logic ALE = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  state_e          state_q, state_d;
  logic            start_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      ext_q, ext_d;
  logic [1:0]      off_q, off_d;
  logic [31:0]     ld_data_q, ld_data_d;
  logic            ld_err_q, ld_err_d;
  logic            ld_ale_q, ld_ale_d;
  logic            is_load, aligned;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     ext_data;
  logic            addr_unused;
  assign addr_unused = ^mem_ram_addr[31:2];
  assign is_load   = start_q & (mem_wd_sel == `WD_RAM) & (mem_ram_we == 4'h0);
  assign mem_stall = is_load | (state_q == WAIT);
  assign ld_valid  = (state_q == DONE);
  assign ld_data   = ld_data_q;
  assign ld_err    = ld_err_q;
  assign ld_ale    = ld_ale_q;
  always_comb begin
    aligned = (mem_ram_ext_op == `RAM_EXT_B || mem_ram_ext_op == `RAM_EXT_BU) ? 1'b1 :
              (mem_ram_ext_op == `RAM_EXT_H || mem_ram_ext_op == `RAM_EXT_HU) ? ~mem_ram_addr[0] :
              (mem_ram_addr[1:0] == 2'b00);
    byte_v   = 8'(da_rdata >> {off_q, 3'b000});
    half_v   = off_q[1] ? da_rdata[31:16] : da_rdata[15:0];
    ext_data = (ext_q == `RAM_EXT_B)  ? {{24{byte_v[7]}}, byte_v} :
               (ext_q == `RAM_EXT_BU) ? {24'h0, byte_v} :
               (ext_q == `RAM_EXT_H)  ? {{16{half_v[15]}}, half_v} :
               (ext_q == `RAM_EXT_HU) ? {16'h0, half_v} : da_rdata;
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ext_d     = ext_q;
    off_d     = off_q;
    ld_data_d = ld_data_q;
    ld_err_d  = ld_err_q;
    ld_ale_d  = ld_ale_q;
    case (state_q)
      IDLE: if (is_load) begin
        if (aligned) begin
          ext_d   = mem_ram_ext_op;
          off_d   = mem_ram_addr[1:0];
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          ld_data_d = '0;
          ld_err_d  = 1'b0;
          ld_ale_d  = ALE;
          state_d   = DONE;
        end
      end
      WAIT: if (da_rvalid) begin
        ld_data_d = ext_data;
        ld_err_d  = 1'b0;
        ld_ale_d  = 1'b0;
        state_d   = DONE;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        ld_data_d = '0;
        ld_err_d  = 1'b1;
        ld_ale_d  = 1'b0;
        state_d   = DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      cnt_q     <= '0;
      ext_q     <= '0;
      off_q     <= '0;
      ld_data_q <= '0;
      ld_err_q  <= 1'b0;
      ld_ale_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= ex_valid;
      cnt_q     <= cnt_d;
      ext_q     <= ext_d;
      off_q     <= off_d;
      ld_data_q <= ld_data_d;
      ld_err_q  <= ld_err_d;
      ld_ale_q  <= ld_ale_d;
    end
  end
endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: directed loads with a queue scoreboard checked by a ld_valid monitor.
`timescale 1ns/1ps
module tb_mem_resp;
  localparam logic [1:0] WD_RAM = 2'd1;
  localparam logic [2:0] B = 3'd0, BU = 3'd1, H = 3'd2, HU = 3'd3, W = 3'd4;
`ifdef MEM_RESP_ALE_EN
  localparam logic ALE = 1'b1;
`else
  localparam logic ALE = 1'b0;
`endif
  logic        clk = 1'b0, rstn = 1'b0, ex_valid = 1'b0, da_rvalid = 1'b0;
  logic [1:0]  mem_wd_sel = 2'd0;
  logic [31:0] mem_ram_addr = '0, da_rdata = '0;
  logic [2:0]  mem_ram_ext_op = '0;
  logic [3:0]  mem_ram_we = '0;
  logic        mem_stall, ld_valid, ld_err, ld_ale;
  logic [31:0] ld_data;
  int vectors = 0, miscompares = 0;
  logic [33:0] exp_q[$];

  mem_resp #(.TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .mem_wd_sel(mem_wd_sel),
    .mem_ram_addr(mem_ram_addr), .mem_ram_ext_op(mem_ram_ext_op), .mem_ram_we(mem_ram_we),
    .da_rdata(da_rdata), .da_rvalid(da_rvalid), .mem_stall(mem_stall), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_err(ld_err), .ld_ale(ld_ale)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ld_valid) begin
      logic [33:0] e;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL resp_unexpected: got data=%h err=%b ale=%b expected no response", ld_data, ld_err, ld_ale);
      end else begin
        e = exp_q.pop_front();
        if ({ld_data, ld_err, ld_ale} !== e) begin
          miscompares++;
          $display("FAIL resp: got data=%h err=%b ale=%b expected data=%h err=%b ale=%b",
                   ld_data, ld_err, ld_ale, e[33:2], e[1], e[0]);
        end
      end
    end
  end

  // d = cycles between start_q and the cycle carrying rvalid (or the final WAIT cycle if give=0)
  task automatic load(input logic [2:0] ext, input logic [31:0] addr, input logic [31:0] rdata,
                      input int d, input bit give, input int exp_stall, input logic [33:0] exp);
    int st = 0;
    exp_q.push_back(exp);
    ex_valid = 1'b1; mem_wd_sel = WD_RAM; mem_ram_we = 4'h0;
    mem_ram_ext_op = ext; mem_ram_addr = addr;
    step();
    ex_valid = 1'b0;
    for (int i = 0; i < d; i++) begin
      st += int'(mem_stall);
      step();
    end
    st += int'(mem_stall);
    if (give) begin
      da_rvalid = 1'b1;
      da_rdata = rdata;
    end
    step();
    da_rvalid = 1'b0;
    da_rdata = '0;
    chk("ld_valid_pulse", 32'(ld_valid), 32'd1);
    chk("stall_in_done", 32'(mem_stall), 32'd0);
    chk("stall_cycles", st, exp_stall);
    step();
    chk("ld_valid_drop", 32'(ld_valid), 32'd0);
    chk("ld_data_hold", ld_data, exp[33:2]);
  endtask

  task automatic non_load(input logic [1:0] sel, input logic [3:0] we);
    ex_valid = 1'b1; mem_wd_sel = sel; mem_ram_we = we;
    mem_ram_ext_op = W; mem_ram_addr = 32'h8000;
    step();
    ex_valid = 1'b0;
    chk("nonload_stall", 32'(mem_stall), 32'd0);
    step();
    chk("nonload_valid", 32'(ld_valid), 32'd0);
    step();
  endtask

  initial begin
    #2;
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_valid", 32'(ld_valid), 32'd0);
    chk("rst_out", {ld_data[29:0], ld_err, ld_ale}, 32'd0);
    step(); step();
    rstn = 1'b1;
    step();
    load(B,  32'h1003, 32'h8011_2233, 2, 1'b1, 3, {32'hFFFF_FF80, 1'b0, 1'b0});
    load(HU, 32'h2002, 32'hBEEF_1234, 1, 1'b1, 2, {32'h0000_BEEF, 1'b0, 1'b0});
    load(H,  32'h2002, 32'hBEEF_1234, 1, 1'b1, 2, {32'hFFFF_BEEF, 1'b0, 1'b0});
    load(H,  32'h2000, 32'h1234_8001, 1, 1'b1, 2, {32'hFFFF_8001, 1'b0, 1'b0});
    load(BU, 32'h2001, 32'h0000_F100, 1, 1'b1, 2, {32'h0000_00F1, 1'b0, 1'b0});
    load(W,  32'h3001, 32'h0,         0, 1'b0, 1, {32'h0,         1'b0, ALE});
    load(HU, 32'h3003, 32'h0,         0, 1'b0, 1, {32'h0,         1'b0, ALE});
    load(W,  32'h4000, 32'h0,         4, 1'b0, 5, {32'h0,         1'b1, 1'b0});
    load(W,  32'h4000, 32'hCAFE_F00D, 4, 1'b1, 5, {32'hCAFE_F00D, 1'b0, 1'b0});
    non_load(WD_RAM, 4'hF);
    non_load(2'd0, 4'h0);
    da_rvalid = 1'b1; da_rdata = 32'h1234_5678;
    step();
    da_rvalid = 1'b0;
    chk("idle_rvalid", 32'(ld_valid), 32'd0);
    step();
    chk("idle_rvalid_after", 32'(ld_valid), 32'd0);
    ex_valid = 1'b1; mem_wd_sel = WD_RAM; mem_ram_we = 4'h0;
    mem_ram_ext_op = W; mem_ram_addr = 32'h6000;
    step();
    ex_valid = 1'b0;
    step();
    chk("wait_stall", 32'(mem_stall), 32'd1);
    rstn = 1'b0;
    #1;
    chk("midrst_stall", 32'(mem_stall), 32'd0);
    chk("midrst_out", {ld_data[29:0], ld_err, ld_ale}, 32'd0);
    step();
    rstn = 1'b1;
    step();
    da_rvalid = 1'b1; da_rdata = 32'hAAAA_5555;
    step();
    da_rvalid = 1'b0;
    chk("midrst_rvalid", 32'(ld_valid), 32'd0);
    step();
    chk("midrst_data", ld_data, 32'h0);
    load(BU, 32'h5001, 32'h0000_7F00, 1, 1'b1, 2, {32'h0000_007F, 1'b0, 1'b0});
    step(); step();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
